mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter ADDR_W, default 9, byte-address width of the data memory.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  1  pipeline access request present.
REQ-005 req_ready  out  1  controller can accept a request.
REQ-006 req_addr  in  ADDR_W  byte address.
REQ-007 req_size  in  2  00 byte, 01 halfword, 10 word, 11 doubleword.
REQ-008 req_rw  in  1  0 load, 1 store.
REQ-009 req_se  in  1  sign-extend byte/halfword loads.
REQ-010 req_wdata  in  64  store data; byte/half/word use low bits, doubleword uses all 64.
REQ-011 resp_valid  out  1  access complete.
REQ-012 resp_ready  in  1  consumer accepts response.
REQ-013 resp_rdata  out  64  load result; zero for stores.
REQ-014 resp_err  out  1  misaligned-address fault.
REQ-015 mem_A  out  ADDR_W, mem_DI  out  32, mem_Size  out  2, mem_RW  out  1, mem_E  out  1, mem_SE  out  1: memory drive ports, same encodings as the data memory.
REQ-016 mem_DO  in  32  combinational read data from memory.

Function
REQ-017 FSM states IDLE, ACC0, ACC1, RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 IDLE: on req_valid, latch addr/size/rw/se/wdata; aligned -> ACC0, misaligned -> RESP with err=1.
REQ-019 Alignment: half requires addr[0]=0, word addr[1:0]=0, doubleword addr[2:0]=0; byte always aligned.
REQ-020 Misaligned requests SHALL never assert mem_E.
REQ-021 ACC0: mem_E=1, mem_A=addr, mem_RW=rw, mem_SE=se, mem_Size=size (10 for doubleword), mem_DI=wdata[31:0] (wdata[63:32] for doubleword).
REQ-022 ACC1 (doubleword only): mem_E=1, mem_Size=10, mem_A=addr+4, mem_DI=wdata[31:0].
REQ-023 Loads capture mem_DO at the posedge ending each ACC cycle: non-doubleword -> rdata[31:0] with rdata[63:32]=0; doubleword ACC0 -> rdata[63:32], ACC1 -> rdata[31:0] (big-endian).
REQ-024 Stores commit at the posedge ending each ACC cycle; rdata SHALL be 0.
REQ-025 ACC0 -> ACC1 for doubleword, else -> RESP; ACC1 -> RESP.
REQ-026 RESP: resp_valid=1, rdata/err held stable until resp_ready; on resp_ready -> IDLE; err clears on leaving RESP.
REQ-027 Latency: request accepted at edge N -> resp_valid at cycle N+2 (single access), N+3 (doubleword), N+1 (misaligned).
REQ-028 Outside ACC0/ACC1 all mem_* outputs SHALL be 0.
REQ-029 No new request accepted in the cycle resp_ready completes a response (IDLE first).
REQ-030 Address arithmetic modulo 2^ADDR_W; aligned doubleword never wraps.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, all mem_* outputs 0.
REQ-032 Reset mid-access SHALL abort; a partially written doubleword stays partially written; no response is issued.

Structure
REQ-033 Package mem_access_pkg SHALL hold size encodings (SZ_BYTE..SZ_DWORD), RW encodings, and the FSM state type.
REQ-034 One sub-module, mem_align_chk (combinational: addr, size -> misaligned), SHALL be instantiated.

Verification
REQ-035 Word load addr 0x010, memory bytes DE AD BE EF -> rdata 0x00000000DEADBEEF, err 0, resp_valid 2 cycles after accept.
REQ-036 Byte load addr 0x013 value 0x80, se=1 -> rdata 0x00000000FFFFFF80; se=0 -> 0x0000000000000080.
REQ-037 Doubleword store 0x1122334455667788 at 0x020 then doubleword load 0x020 -> rdata 0x1122334455667788; store shows two mem_E cycles at A=0x020, 0x024.
REQ-038 Word load addr 0x011 -> err=1 at cycle after accept, mem_E never 1, rdata 0.
REQ-039 resp_ready held low 5 cycles -> resp_valid, rdata stable all 5 cycles, req_ready 0 throughout.
REQ-040 rst_n asserted during ACC1 of doubleword store -> outputs at reset values immediately, 0x024..0x027 unchanged, next request completes normally.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared encodings and FSM state type for the
// load/store memory access controller.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [1:0] SZ_DWORD = 2'b11;

    localparam logic RW_LOAD  = 1'b0;
    localparam logic RW_STORE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC0,
        ST_ACC1,
        ST_RESP
    } state_t;

endpackage

// File: rtl/mem_align_chk.sv
// Natural-alignment check for an access; only the
// low three address bits can make an access misaligned.
module mem_align_chk
    import mem_access_pkg::*;
(
    input  logic [2:0] addr,
    input  logic [1:0] size,
    output logic       misaligned
);

    always_comb begin
        misaligned = 1'b0;
        unique case (size)
            SZ_BYTE:  misaligned = 1'b0;
            SZ_HALF:  misaligned = addr[0];
            SZ_WORD:  misaligned = |addr[1:0];
            SZ_DWORD: misaligned = |addr[2:0];
            default:  misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller: splits doublewords into two
// big-endian word accesses and faults misaligned requests.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_rw,
    input  logic              req_se,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [63:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_A,
    output logic [31:0]       mem_DI,
    output logic [1:0]        mem_Size,
    output logic              mem_RW,
    output logic              mem_E,
    output logic              mem_SE,
    input  logic [31:0]       mem_DO
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              rw_q, rw_d;
    logic              se_q, se_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [63:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              misaligned;
    logic              is_dw;

    mem_align_chk u_align (
        .addr       (req_addr[2:0]),
        .size       (req_size),
        .misaligned (misaligned)
    );

    assign is_dw      = (size_q == SZ_DWORD);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            size_q  <= SZ_BYTE;
            rw_q    <= RW_LOAD;
            se_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            rw_q    <= rw_d;
            se_q    <= se_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        rw_d       = rw_q;
        se_d       = se_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_E      = 1'b0;
        mem_A      = '0;
        mem_DI     = '0;
        mem_Size   = SZ_BYTE;
        mem_RW     = 1'b0;
        mem_SE     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d  = req_addr;
                    size_d  = req_size;
                    rw_d    = req_rw;
                    se_d    = req_se;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    if (misaligned) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_ACC0;
                    end
                end
            end
            ST_ACC0: begin
                mem_E    = 1'b1;
                mem_A    = addr_q;
                mem_RW   = rw_q;
                mem_SE   = se_q;
                mem_Size = is_dw ? SZ_WORD : size_q;
                mem_DI   = is_dw ? wdata_q[63:32] : wdata_q[31:0];
                // Doublewords are big-endian: first word is the high half
                if (rw_q == RW_LOAD) begin
                    if (is_dw) rdata_d[63:32] = mem_DO;
                    else       rdata_d        = {32'h0, mem_DO};
                end
                state_d = is_dw ? ST_ACC1 : ST_RESP;
            end
            ST_ACC1: begin
                mem_E    = 1'b1;
                mem_A    = addr_q + ADDR_W'(4);
                mem_RW   = rw_q;
                mem_Size = SZ_WORD;
                mem_DI   = wdata_q[31:0];
                if (rw_q == RW_LOAD) rdata_d[31:0] = mem_DO;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    err_d   = 1'b0;
                    rdata_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a big-endian
// byte-addressed memory model.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [8:0]  req_addr;
    logic [1:0]  req_size;
    logic        req_rw;
    logic        req_se;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic [8:0]  mem_A;
    logic [31:0] mem_DI;
    logic [1:0]  mem_Size;
    logic        mem_RW;
    logic        mem_E;
    logic        mem_SE;
    logic [31:0] mem_DO;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:511];
    logic       pl_en = 1'b0;
    logic [8:0] pl_a  = '0;
    logic [7:0] pl_d  = '0;
    logic [8:0] ma1, ma2, ma3;
    int         me_cnt = 0;
    logic [8:0] me_prev = '0;
    logic [8:0] me_last = '0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(9)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_rw     (req_rw),
        .req_se     (req_se),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_A      (mem_A),
        .mem_DI     (mem_DI),
        .mem_Size   (mem_Size),
        .mem_RW     (mem_RW),
        .mem_E      (mem_E),
        .mem_SE     (mem_SE),
        .mem_DO     (mem_DO)
    );

    assign ma1 = mem_A + 9'd1;
    assign ma2 = mem_A + 9'd2;
    assign ma3 = mem_A + 9'd3;

    always_comb begin
        mem_DO = '0;
        case (mem_Size)
            2'b00: mem_DO = mem_SE ? {{24{mem[mem_A][7]}}, mem[mem_A]}
                                   : {24'h0, mem[mem_A]};
            2'b01: mem_DO = mem_SE ? {{16{mem[mem_A][7]}}, mem[mem_A], mem[ma1]}
                                   : {16'h0, mem[mem_A], mem[ma1]};
            default: mem_DO = {mem[mem_A], mem[ma1], mem[ma2], mem[ma3]};
        endcase
    end

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_a] <= pl_d;
        end else if (mem_E && mem_RW) begin
            case (mem_Size)
                2'b00: mem[mem_A] <= mem_DI[7:0];
                2'b01: begin
                    mem[mem_A] <= mem_DI[15:8];
                    mem[ma1]   <= mem_DI[7:0];
                end
                default: begin
                    mem[mem_A] <= mem_DI[31:24];
                    mem[ma1]   <= mem_DI[23:16];
                    mem[ma2]   <= mem_DI[15:8];
                    mem[ma3]   <= mem_DI[7:0];
                end
            endcase
        end
        if (mem_E) begin
            me_cnt  <= me_cnt + 1;
            me_prev <= me_last;
            me_last <= mem_A;
        end
    end

    task automatic poke(input logic [8:0] a, input logic [7:0] d);
        pl_a  = a;
        pl_d  = d;
        pl_en = 1'b1;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // Present one request, wait for resp_valid; lat = edges after accept
    task automatic issue(input logic [8:0] a, input logic [1:0] sz,
                         input logic rw, input logic se,
                         input logic [63:0] wd, output int lat);
        req_valid = 1'b1;
        req_addr  = a;
        req_size  = sz;
        req_rw    = rw;
        req_se    = se;
        req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL rst_req_ready got %b exp 1", req_ready);
        end
        checks++;
        if (resp_valid !== 1'b0 || resp_err !== 1'b0) begin
            errors++; $display("FAIL rst_resp got v=%b e=%b exp 0 0", resp_valid, resp_err);
        end
        checks++;
        if (resp_rdata !== 64'h0) begin
            errors++; $display("FAIL rst_rdata got %h exp 0", resp_rdata);
        end
        checks++;
        if ({mem_E, mem_RW, mem_SE, mem_Size, mem_A, mem_DI} !== 46'h0) begin
            errors++; $display("FAIL rst_mem got E=%b A=%h DI=%h exp all 0", mem_E, mem_A, mem_DI);
        end
    endtask

    task automatic test_word_load();
        int lat, c0;
        poke(9'h010, 8'hDE); poke(9'h011, 8'hAD);
        poke(9'h012, 8'hBE); poke(9'h013, 8'hEF);
        c0 = me_cnt;
        issue(9'h010, 2'b10, 1'b0, 1'b0, 64'h0, lat);
        checks++;
        if (lat !== 1) begin
            errors++; $display("FAIL word_latency got %0d exp 1", lat);
        end
        checks++;
        if (resp_rdata !== 64'h00000000DEADBEEF || resp_err !== 1'b0) begin
            errors++; $display("FAIL word_load got %h err %b exp 00000000deadbeef err 0", resp_rdata, resp_err);
        end
        checks++;
        if (me_cnt - c0 !== 1 || req_ready !== 1'b0) begin
            errors++; $display("FAIL word_mem_e got %0d rr %b exp 1 rr 0", me_cnt - c0, req_ready);
        end
        finish_resp();
    endtask

    task automatic test_byte_load();
        int lat;
        poke(9'h013, 8'h80);
        issue(9'h013, 2'b00, 1'b0, 1'b1, 64'h0, lat);
        checks++;
        if (lat !== 1 || resp_rdata !== 64'h00000000FFFFFF80) begin
            errors++; $display("FAIL byte_se got %h lat %0d exp 00000000ffffff80 lat 1", resp_rdata, lat);
        end
        finish_resp();
        issue(9'h013, 2'b00, 1'b0, 1'b0, 64'h0, lat);
        checks++;
        if (resp_rdata !== 64'h0000000000000080) begin
            errors++; $display("FAIL byte_ze got %h exp 0000000000000080", resp_rdata);
        end
        finish_resp();
    endtask

    task automatic test_half_wrap();
        int lat;
        issue(9'h1FE, 2'b01, 1'b1, 1'b0, 64'h12345678_9ABCA5C3, lat);
        finish_resp();
        issue(9'h1FE, 2'b01, 1'b0, 1'b1, 64'h0, lat);
        checks++;
        if (resp_rdata !== 64'h00000000FFFFA5C3) begin
            errors++; $display("FAIL half_top got %h exp 00000000ffffa5c3", resp_rdata);
        end
        finish_resp();
    endtask

    task automatic test_dword();
        int lat, c0;
        c0 = me_cnt;
        issue(9'h020, 2'b11, 1'b1, 1'b0, 64'h1122334455667788, lat);
        checks++;
        if (lat !== 2 || resp_rdata !== 64'h0) begin
            errors++; $display("FAIL dw_store got lat %0d rdata %h exp 2 0", lat, resp_rdata);
        end
        checks++;
        if (me_cnt - c0 !== 2 || me_prev !== 9'h020 || me_last !== 9'h024) begin
            errors++; $display("FAIL dw_store_mem got n=%0d a=%h,%h exp 2 020,024", me_cnt - c0, me_prev, me_last);
        end
        finish_resp();
        issue(9'h020, 2'b11, 1'b0, 1'b0, 64'h0, lat);
        checks++;
        if (lat !== 2 || resp_rdata !== 64'h1122334455667788) begin
            errors++; $display("FAIL dw_load got %h lat %0d exp 1122334455667788 lat 2", resp_rdata, lat);
        end
        finish_resp();
    endtask

    task automatic test_misaligned();
        int lat, c0;
        c0 = me_cnt;
        issue(9'h011, 2'b10, 1'b0, 1'b0, 64'h0, lat);
        checks++;
        if (lat !== 0 || resp_err !== 1'b1 || resp_rdata !== 64'h0) begin
            errors++; $display("FAIL mis_word got lat %0d err %b rdata %h exp 0 1 0", lat, resp_err, resp_rdata);
        end
        finish_resp();
        checks++;
        if (resp_err !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL mis_clear got err %b rr %b exp 0 1", resp_err, req_ready);
        end
        issue(9'h013, 2'b01, 1'b1, 1'b0, 64'hFFFF, lat);
        finish_resp();
        issue(9'h024, 2'b11, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, lat);
        checks++;
        if (lat !== 0 || resp_err !== 1'b1) begin
            errors++; $display("FAIL mis_dw got lat %0d err %b exp 0 1", lat, resp_err);
        end
        finish_resp();
        checks++;
        if (me_cnt - c0 !== 0) begin
            errors++; $display("FAIL mis_mem_e got %0d exp 0", me_cnt - c0);
        end
    endtask

    task automatic test_stall();
        int lat;
        issue(9'h010, 2'b10, 1'b0, 1'b0, 64'h0, lat);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (resp_valid !== 1'b1 || req_ready !== 1'b0 ||
                resp_rdata !== 64'h00000000DEADBE80 || mem_E !== 1'b0) begin
                errors++;
                $display("FAIL stall_%0d got v=%b rr=%b rdata=%h E=%b exp 1 0 00000000deadbe80 0",
                         i, resp_valid, req_ready, resp_rdata, mem_E);
            end
            @(posedge clk); #1;
        end
        finish_resp();
    endtask

    task automatic test_back_to_back();
        int lat;
        issue(9'h010, 2'b10, 1'b0, 1'b0, 64'h0, lat);
        req_valid  = 1'b1;
        req_addr   = 9'h010;
        req_size   = 2'b00;
        req_rw     = 1'b0;
        req_se     = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_E !== 1'b0) begin
            errors++; $display("FAIL b2b_idle got v=%b rr=%b E=%b exp 0 1 0", resp_valid, req_ready, mem_E);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (mem_E !== 1'b1 || mem_A !== 9'h010 || mem_Size !== 2'b00) begin
            errors++; $display("FAIL b2b_acc got E=%b A=%h sz=%b exp 1 010 00", mem_E, mem_A, mem_Size);
        end
        @(posedge clk); #1;
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 64'h00000000000000DE) begin
            errors++; $display("FAIL b2b_resp got v=%b rdata=%h exp 1 00000000000000de", resp_valid, resp_rdata);
        end
        finish_resp();
    endtask

    task automatic test_reset_mid();
        int lat;
        req_valid = 1'b1;
        req_addr  = 9'h020;
        req_size  = 2'b11;
        req_rw    = 1'b1;
        req_se    = 1'b0;
        req_wdata = 64'hAABBCCDD_01020304;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (mem_E !== 1'b1 || mem_A !== 9'h024) begin
            errors++; $display("FAIL mid_acc1 got E=%b A=%h exp 1 024", mem_E, mem_A);
        end
        rst_n = 1'b0;
        #1;
        test_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if ({mem[9'h020], mem[9'h021], mem[9'h022], mem[9'h023],
             mem[9'h024], mem[9'h025], mem[9'h026], mem[9'h027]} !== 64'hAABBCCDD55667788) begin
            errors++;
            $display("FAIL mid_partial got %h%h%h%h%h%h%h%h exp aabbccdd55667788",
                     mem[9'h020], mem[9'h021], mem[9'h022], mem[9'h023],
                     mem[9'h024], mem[9'h025], mem[9'h026], mem[9'h027]);
        end
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++; $display("FAIL mid_noresp got %b exp 0", resp_valid);
        end
        @(posedge clk); #1;
        issue(9'h024, 2'b10, 1'b0, 1'b0, 64'h0, lat);
        checks++;
        if (lat !== 1 || resp_rdata !== 64'h0000000055667788) begin
            errors++; $display("FAIL mid_after got %h lat %0d exp 0000000055667788 lat 1", resp_rdata, lat);
        end
        finish_resp();
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_size   = '0;
        req_rw     = 1'b0;
        req_se     = 1'b0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        #1;
        test_reset();
        #11;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_word_load();
        test_byte_load();
        test_half_wrap();
        test_dword();
        test_misaligned();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
